// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and helpers for the 4-channel TDM select/data link.
//   NUM_CH    number of multiplexed channels
//   CH_W      width of a slot index / demux select
//   SLOT_C1..SLOT_C4  slot encodings ({S2,S1}) for channels 1..4
//   next_req_slot()   round-robin search used when idle slots are skipped
//                     (SKIP_IDLE_EN build option of tdm_mux_4)
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  localparam logic [CH_W-1:0] SLOT_C1 = 2'd0;
  localparam logic [CH_W-1:0] SLOT_C2 = 2'd1;
  localparam logic [CH_W-1:0] SLOT_C3 = 2'd2;
  localparam logic [CH_W-1:0] SLOT_C4 = 2'd3;

  // First requesting slot after cur in round-robin order, cur itself checked
  // last. Scanning from the farthest offset down lets the nearest hit win.
  // No requester at all falls back to channel 1.
  function automatic logic [CH_W-1:0] next_req_slot(input logic [CH_W-1:0]   cur,
                                                     input logic [NUM_CH-1:0] req);
    logic [CH_W-1:0] cand;
    logic [CH_W-1:0] nxt;
    nxt = SLOT_C1;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = cur + CH_W'(k);
      if (req[cand]) nxt = cand;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tdm_mux_4_mux.sv
// mux_4: combinational 4:1 multiplexer, WIDTH bits wide, written as an
// AND-OR tree with decoded selects so it maps directly onto and/or/not cells.
//   d0..d3  in   WIDTH  data inputs (d0 chosen for sel=0)
//   sel     in   2      select
//   y       out  WIDTH  selected data
module mux_4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [CH_W-1:0]  sel,
  output logic [WIDTH-1:0] y
);

  logic sel0_n;
  logic sel1_n;
  logic [3:0] dec;

  assign sel0_n = ~sel[0];
  assign sel1_n = ~sel[1];

  assign dec[0] = sel1_n & sel0_n;
  assign dec[1] = sel1_n & sel[0];
  assign dec[2] = sel[1] & sel0_n;
  assign dec[3] = sel[1] & sel[0];

  assign y = ({WIDTH{dec[0]}} & d0) |
             ({WIDTH{dec[1]}} & d1) |
             ({WIDTH{dec[2]}} & d2) |
             ({WIDTH{dec[3]}} & d3);

endmodule

// File: rtl/tdm_mux_4.sv
// tdm_mux_4: transmit end of a 4-channel select/data TDM link. A slot counter
// rotates through channels 1..4, holding each slot DWELL enabled cycles, and
// drives the downstream demux select {S2,S1} together with the sampled data.
// All outputs are registered (latency 1 from inputs).
//   clk     in   1      clock
//   rst     in   1      synchronous reset, active-high (wins over en)
//   en      in   1      advance enable; 0 freezes all state, frame forced 0
//   I1..I4  in   WIDTH  channel data
//   R1..R4  in   1      channel requests
//   S1, S2  out  1      demux select LSB / MSB
//   O       out  WIDTH  muxed data, zero when the slot channel is not requesting
//   V       out  1      O is valid data of channel {S2,S1}+1
//   frame   out  1      one-cycle pulse when slot 0 is first shown
// Build option: SKIP_IDLE_EN -- when defined, slot advance jumps to the next
// requesting channel (round-robin, current last); with no requester slot 0
// holds. Undefined: fixed rotation 0,1,2,3.
module tdm_mux_4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DWELL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic [WIDTH-1:0] I4,
  input  logic             R1,
  input  logic             R2,
  input  logic             R3,
  input  logic             R4,
  output logic             S1,
  output logic             S2,
  output logic [WIDTH-1:0] O,
  output logic             V,
  output logic             frame
);

  localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  logic [CH_W-1:0]  slot;
  logic [CH_W-1:0]  slot_nxt;
  logic [DW_W-1:0]  dwell;
  logic [WIDTH-1:0] data_sel;
  logic             req_sel;
  logic             advance;
  // Set when the slot register has just been (re)loaded with a different
  // slot, or after reset; frame fires on the first enabled cycle showing
  // slot 0 while this is set, so a held slot 0 does not pulse again.
  logic             fresh;

  mux_4 #(.WIDTH(WIDTH)) u_data_mux (
    .d0  (I1),
    .d1  (I2),
    .d2  (I3),
    .d3  (I4),
    .sel (slot),
    .y   (data_sel)
  );

  mux_4 #(.WIDTH(1)) u_req_mux (
    .d0  (R1),
    .d1  (R2),
    .d2  (R3),
    .d3  (R4),
    .sel (slot),
    .y   (req_sel)
  );

  assign advance = (dwell == DWELL_LAST);

  always_comb begin
    slot_nxt = SLOT_C1;
`ifdef SKIP_IDLE_EN
    slot_nxt = next_req_slot(slot, {R4, R3, R2, R1});
`else
    slot_nxt = slot + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= SLOT_C1;
      dwell    <= '0;
      fresh    <= 1'b1;
      {S2, S1} <= SLOT_C1;
      O        <= '0;
      V        <= 1'b0;
      frame    <= 1'b0;
    end else if (en) begin
      {S2, S1} <= slot;
      O        <= req_sel ? data_sel : '0;
      V        <= req_sel;
      frame    <= fresh && (slot == SLOT_C1);
      if (advance) begin
        dwell <= '0;
        slot  <= slot_nxt;
        fresh <= (slot_nxt != slot);
      end else begin
        dwell <= dwell + 1'b1;
        fresh <= 1'b0;
      end
    end else begin
      frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_mux_4.sv
module tb_tdm_mux_4;

  logic clk;
  logic rst;
  logic en;
  logic i1, i2, i3, i4;
  logic r1, r2, r3, r4;

  logic s1_a, s2_a, o_a, v_a, fr_a;
  logic s1_b, s2_b, o_b, v_b, fr_b;

  // Observation vectors: {S2,S1,O,V,frame}
  logic [4:0] obs_a;
  logic [4:0] obs_b;
  assign obs_a = {s2_a, s1_a, o_a, v_a, fr_a};
  assign obs_b = {s2_b, s1_b, o_b, v_b, fr_b};

  int n_checks;
  int n_fail;

  // DWELL=1 instance
  tdm_mux_4 #(.WIDTH(1), .DWELL(1)) u_dw1 (
    .clk (clk), .rst (rst), .en (en),
    .I1 (i1), .I2 (i2), .I3 (i3), .I4 (i4),
    .R1 (r1), .R2 (r2), .R3 (r3), .R4 (r4),
    .S1 (s1_a), .S2 (s2_a), .O (o_a), .V (v_a), .frame (fr_a)
  );

  // DWELL=3 instance
  tdm_mux_4 #(.WIDTH(1), .DWELL(3)) u_dw3 (
    .clk (clk), .rst (rst), .en (en),
    .I1 (i1), .I2 (i2), .I3 (i3), .I4 (i4),
    .R1 (r1), .R2 (r2), .R3 (r3), .R4 (r4),
    .S1 (s1_b), .S2 (s2_b), .O (o_b), .V (v_b), .frame (fr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    {i1, i2, i3, i4} = 4'b1011;
    {r4, r3, r2, r1} = 4'b1111;
    tick();
    tick();
    n_checks++;
    if (obs_a !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_dw1 got=%b want=%b", obs_a, 5'b00000);
    end
    n_checks++;
    if (obs_b !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_dw3 got=%b want=%b", obs_b, 5'b00000);
    end
    rst = 1'b0;
  endtask

  task automatic test_dwell1_rotation();
    logic [3:0] ivec;
    logic [1:0] sl;
    logic [4:0] exp;
    ivec = 4'b1101;               // {I4,I3,I2,I1} = 1,1,0,1
    {i4, i3, i2, i1} = ivec;
    {r4, r3, r2, r1} = 4'b1111;
    en = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      sl  = 2'(k % 4);
      exp = {sl, ivec[sl], 1'b1, (sl == 2'd0)};
      n_checks++;
      if (obs_a !== exp) begin
        n_fail++;
        $display("FAIL dwell1_cycle%0d got=%b want=%b", k, obs_a, exp);
      end
    end
  endtask

  task automatic test_dwell3_norequest();
    logic [1:0] sl;
    logic       v;
    logic [4:0] exp;
    {i4, i3, i2, i1} = 4'b1111;
    {r4, r3, r2, r1} = 4'b1101;   // R2 idle
    en = 1'b1;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick();
      sl  = 2'(k / 3);
      v   = (sl != 2'd1);
      exp = {sl, v, v, (k == 0)};
      n_checks++;
      if (obs_b !== exp) begin
        n_fail++;
        $display("FAIL dwell3_cycle%0d got=%b want=%b", k, obs_b, exp);
      end
    end
  endtask

  task automatic test_enable_freeze();
    {i4, i3, i2, i1} = 4'b1111;
    {r4, r3, r2, r1} = 4'b1111;
    en = 1'b1;
    do_reset();
    for (int k = 0; k < 7; k++) tick();   // first cycle of slot 2 shown
    en = 1'b0;
    i3 = 1'b0;                            // change must not leak while frozen
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (obs_b !== 5'b10110) begin
        n_fail++;
        $display("FAIL freeze_cycle%0d got=%b want=%b", k, obs_b, 5'b10110);
      end
    end
    en = 1'b1;
    // Remaining two cycles of slot 2 (I3 now resampled as 0), then slot 3
    tick();
    n_checks++;
    if (obs_b !== 5'b10010) begin
      n_fail++;
      $display("FAIL resume_cycle0 got=%b want=%b", obs_b, 5'b10010);
    end
    tick();
    n_checks++;
    if (obs_b !== 5'b10010) begin
      n_fail++;
      $display("FAIL resume_cycle1 got=%b want=%b", obs_b, 5'b10010);
    end
    tick();
    n_checks++;
    if (obs_b !== 5'b11110) begin
      n_fail++;
      $display("FAIL resume_cycle2 got=%b want=%b", obs_b, 5'b11110);
    end
    i3 = 1'b1;
  endtask

  task automatic test_reset_midslot();
    {i4, i3, i2, i1} = 4'b1111;
    {r4, r3, r2, r1} = 4'b1111;
    en = 1'b1;
    do_reset();
    for (int k = 0; k < 10; k++) tick();  // in slot 3
    n_checks++;
    if (obs_b !== 5'b11110) begin
      n_fail++;
      $display("FAIL pre_reset_slot3 got=%b want=%b", obs_b, 5'b11110);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs_b !== 5'b00000) begin
      n_fail++;
      $display("FAIL midslot_reset got=%b want=%b", obs_b, 5'b00000);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (obs_b !== 5'b00111) begin
      n_fail++;
      $display("FAIL restart_c0 got=%b want=%b", obs_b, 5'b00111);
    end
    tick();
    tick();
    tick();
    n_checks++;
    if (obs_b !== 5'b01110) begin
      n_fail++;
      $display("FAIL restart_slot1 got=%b want=%b", obs_b, 5'b01110);
    end
  endtask

`ifdef SKIP_IDLE_EN
  task automatic test_skip_idle();
    logic [1:0] sl;
    logic [4:0] exp;
    {i4, i3, i2, i1} = 4'b1111;
    {r4, r3, r2, r1} = 4'b0101;
    en = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      sl  = (k % 2 == 0) ? 2'd0 : 2'd2;
      exp = {sl, 1'b1, 1'b1, (sl == 2'd0)};
      n_checks++;
      if (obs_a !== exp) begin
        n_fail++;
        $display("FAIL skip_alt_cycle%0d got=%b want=%b", k, obs_a, exp);
      end
    end
    {r4, r3, r2, r1} = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp = {2'd0, 1'b0, 1'b0, (k == 0)};
      n_checks++;
      if (obs_a !== exp) begin
        n_fail++;
        $display("FAIL skip_none_cycle%0d got=%b want=%b", k, obs_a, exp);
      end
    end
  endtask
`else
  task automatic test_fixed_rotation();
    logic [3:0] rvec;
    logic [1:0] sl;
    logic [4:0] exp;
    {i4, i3, i2, i1} = 4'b1111;
    rvec = 4'b0101;
    {r4, r3, r2, r1} = rvec;
    en = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick();
      sl  = 2'(k % 4);
      exp = {sl, rvec[sl], rvec[sl], (sl == 2'd0)};
      n_checks++;
      if (obs_a !== exp) begin
        n_fail++;
        $display("FAIL fixed_rot_cycle%0d got=%b want=%b", k, obs_a, exp);
      end
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; en = 1'b0;
    {i1, i2, i3, i4} = 4'b0000;
    {r1, r2, r3, r4} = 4'b0000;
    test_reset();
    test_dwell1_rotation();
    test_dwell3_norequest();
    test_enable_freeze();
    test_reset_midslot();
`ifdef SKIP_IDLE_EN
    test_skip_idle();
`else
    test_fixed_rotation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
